valu_pipe_seq: RTL and testbench

//  Issue sequencer for the parametrised VALU multiply/add pipeline.

---
 rtl/valu_pipe_seq.sv | 115 +++++++++++
 tb/tb_valu_pipe_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/valu_pipe_seq.sv
// Issue sequencer for the VALU multiply/add pipeline: tracks ops through the
// mult and add stages, drives stage enables, mode bits and the writeback port.
module valu_pipe_seq #(
  parameter int MULT_STAGES = 1,
  parameter int ADD_STAGES  = 1,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [1:0]             issue_op,
  input  logic [TAG_WIDTH-1:0]   issue_tag,
  input  logic                   stall,
  output logic [MULT_STAGES-1:0] mult_pipe_enable,
  output logic [ADD_STAGES-1:0]  add_pipe_enable,
  output logic [MULT_STAGES-1:0] mult_by_one,
  output logic [ADD_STAGES-1:0]  add_to_zero,
  output logic                   save_to_accum,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [TAG_WIDTH-1:0]   wb_tag,
  output logic [1:0]             wb_op,
  output logic                   busy
);

  localparam int N = MULT_STAGES + ADD_STAGES;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MACC = 2'b11;

  // Slot s < MULT_STAGES is mult stage s; slot MULT_STAGES+j is add stage j.
  logic [N-1:0]         vld_p;
  logic [1:0]           op_p  [N];
  logic [TAG_WIDTH-1:0] tag_p [N];

  logic advance;
  logic step;
  logic hazard;
  logic issue_fire;

  function automatic logic is_op(input logic vld, input logic [1:0] op,
                                 input logic [1:0] want);
    return vld && (op == want);
  endfunction

  assign advance     = !stall && (!wb_valid || wb_ready);
  assign step        = advance && !reset;
  assign issue_ready = advance && !hazard && !reset;
  assign issue_fire  = issue_valid && issue_ready;
  assign busy        = (|vld_p) || wb_valid;

  // A MACC within the first ADD_STAGES-1 slots would reach add stage 0 before
  // the older MACC has written the accumulator, so the new MACC must wait.
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s <= ADD_STAGES - 2; s++) begin
      if (is_op(vld_p[s], op_p[s], OP_MACC)) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && (issue_op == OP_MACC);
  end

  always_comb begin
    mult_pipe_enable    = '0;
    add_pipe_enable     = '0;
    mult_by_one         = '0;
    add_to_zero         = '0;
    mult_pipe_enable[0] = step && issue_fire;
    for (int k = 1; k < MULT_STAGES; k++) begin
      mult_pipe_enable[k] = step && vld_p[k-1];
    end
    for (int k = 0; k < MULT_STAGES; k++) begin
      mult_by_one[k] = is_op(vld_p[k], op_p[k], OP_ADD);
    end
    for (int j = 0; j < ADD_STAGES; j++) begin
      add_pipe_enable[j] = step && vld_p[MULT_STAGES+j-1];
      add_to_zero[j]     = is_op(vld_p[MULT_STAGES+j], op_p[MULT_STAGES+j], OP_MULT);
    end
  end

  assign save_to_accum = step && is_op(vld_p[N-1], op_p[N-1], OP_MACC);

  // Slot valids and writeback register: shift in lockstep, bubbles kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p    <= '0;
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_op    <= '0;
    end else if (advance) begin
      vld_p    <= {vld_p[N-2:0], issue_fire};
      wb_valid <= vld_p[N-1];
      wb_tag   <= tag_p[N-1];
      wb_op    <= op_p[N-1];
    end else if (wb_valid && wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  // Slot payloads follow the valids; contents of bubble slots are don't-care.
  always_ff @(posedge clk) begin
    if (advance) begin
      op_p[0]  <= issue_op;
      tag_p[0] <= issue_tag;
      for (int s = 1; s < N; s++) begin
        op_p[s]  <= op_p[s-1];
        tag_p[s] <= tag_p[s-1];
      end
    end
  end

endmodule

// File: tb/tb_valu_pipe_seq.sv
// Scoreboard bench for valu_pipe_seq: three configurations (M2/A1, M1/A2, M3/A1)
// driven with directed vectors; writebacks checked in order against issued ops.
module tb_valu_pipe_seq;

  localparam int TW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int checks   = 0;
  int failures = 0;

  typedef logic [TW+1:0] ent_t;
  ent_t a_q[$];
  ent_t b_q[$];
  ent_t c_q[$];

  // DUT A: M=2 A=1
  logic          a_issue_valid, a_issue_ready, a_stall, a_sta, a_wb_valid, a_wb_ready, a_busy;
  logic [1:0]    a_issue_op, a_wb_op, a_mpe, a_mbo;
  logic [TW-1:0] a_issue_tag, a_wb_tag;
  logic [0:0]    a_ape, a_atz;
  // DUT B: M=1 A=2
  logic          b_issue_valid, b_issue_ready, b_stall, b_sta, b_wb_valid, b_wb_ready, b_busy;
  logic [1:0]    b_issue_op, b_wb_op, b_ape, b_atz;
  logic [TW-1:0] b_issue_tag, b_wb_tag;
  logic [0:0]    b_mpe, b_mbo;
  // DUT C: M=3 A=1
  logic          c_issue_valid, c_issue_ready, c_stall, c_sta, c_wb_valid, c_wb_ready, c_busy;
  logic [1:0]    c_issue_op, c_wb_op;
  logic [2:0]    c_mpe, c_mbo;
  logic [TW-1:0] c_issue_tag, c_wb_tag;
  logic [0:0]    c_ape, c_atz;

  valu_pipe_seq #(.MULT_STAGES(2), .ADD_STAGES(1), .TAG_WIDTH(TW)) u_a (
    .clk(clk), .reset(reset), .issue_valid(a_issue_valid), .issue_ready(a_issue_ready),
    .issue_op(a_issue_op), .issue_tag(a_issue_tag), .stall(a_stall),
    .mult_pipe_enable(a_mpe), .add_pipe_enable(a_ape), .mult_by_one(a_mbo),
    .add_to_zero(a_atz), .save_to_accum(a_sta), .wb_valid(a_wb_valid),
    .wb_ready(a_wb_ready), .wb_tag(a_wb_tag), .wb_op(a_wb_op), .busy(a_busy));

  valu_pipe_seq #(.MULT_STAGES(1), .ADD_STAGES(2), .TAG_WIDTH(TW)) u_b (
    .clk(clk), .reset(reset), .issue_valid(b_issue_valid), .issue_ready(b_issue_ready),
    .issue_op(b_issue_op), .issue_tag(b_issue_tag), .stall(b_stall),
    .mult_pipe_enable(b_mpe), .add_pipe_enable(b_ape), .mult_by_one(b_mbo),
    .add_to_zero(b_atz), .save_to_accum(b_sta), .wb_valid(b_wb_valid),
    .wb_ready(b_wb_ready), .wb_tag(b_wb_tag), .wb_op(b_wb_op), .busy(b_busy));

  valu_pipe_seq #(.MULT_STAGES(3), .ADD_STAGES(1), .TAG_WIDTH(TW)) u_c (
    .clk(clk), .reset(reset), .issue_valid(c_issue_valid), .issue_ready(c_issue_ready),
    .issue_op(c_issue_op), .issue_tag(c_issue_tag), .stall(c_stall),
    .mult_pipe_enable(c_mpe), .add_pipe_enable(c_ape), .mult_by_one(c_mbo),
    .add_to_zero(c_atz), .save_to_accum(c_sta), .wb_valid(c_wb_valid),
    .wb_ready(c_wb_ready), .wb_tag(c_wb_tag), .wb_op(c_wb_op), .busy(c_busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitors: pop on each completed writeback, push on each accepted issue.
  always @(negedge clk) begin
    if (reset) a_q.delete();
    else begin
      if (a_wb_valid && a_wb_ready) begin
        if (a_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_wb_unexpected: got tag %0d op %0d, required no writeback", a_wb_tag, a_wb_op);
        end else chk("a_wb_op_tag", {a_wb_op, a_wb_tag}, a_q.pop_front());
      end
      if (a_issue_valid && a_issue_ready) a_q.push_back({a_issue_op, a_issue_tag});
    end
  end

  always @(negedge clk) begin
    if (reset) b_q.delete();
    else begin
      if (b_wb_valid && b_wb_ready) begin
        if (b_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_wb_unexpected: got tag %0d op %0d, required no writeback", b_wb_tag, b_wb_op);
        end else chk("b_wb_op_tag", {b_wb_op, b_wb_tag}, b_q.pop_front());
      end
      if (b_issue_valid && b_issue_ready) b_q.push_back({b_issue_op, b_issue_tag});
    end
  end

  always @(negedge clk) begin
    if (reset) c_q.delete();
    else begin
      if (c_wb_valid && c_wb_ready) begin
        if (c_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL c_wb_unexpected: got tag %0d op %0d, required no writeback", c_wb_tag, c_wb_op);
        end else chk("c_wb_op_tag", {c_wb_op, c_wb_tag}, c_q.pop_front());
      end
      if (c_issue_valid && c_issue_ready) c_q.push_back({c_issue_op, c_issue_tag});
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: run still active at 20000ns, required finish earlier");
    $fatal(1);
  end

  initial begin
    int sta_cnt;
    logic [2:0] exp_mbo;
    reset = 1'b1;
    a_issue_valid = 0; a_issue_op = 0; a_issue_tag = 0; a_stall = 0; a_wb_ready = 1;
    b_issue_valid = 0; b_issue_op = 0; b_issue_tag = 0; b_stall = 0; b_wb_ready = 1;
    c_issue_valid = 0; c_issue_op = 0; c_issue_tag = 0; c_stall = 0; c_wb_ready = 1;

    nxt();
    mid();
    chk("a_ready_in_reset", a_issue_ready, 0);
    nxt();
    reset = 1'b0;
    mid();
    chk("rst_wb_valid", a_wb_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_wb_tag", a_wb_tag, 0);
    chk("rst_wb_op", a_wb_op, 0);
    chk("rst_enables", {a_mpe, a_ape, a_sta}, 0);
    chk("rst_ready_after", a_issue_ready, 1);
    nxt();

    // MULT latency on M=2 A=1
    for (int c = 0; c < 6; c++) begin
      a_issue_valid = (c == 0); a_issue_op = 2'b00; a_issue_tag = 5;
      mid();
      if (c == 0) begin
        chk("t1_ready", a_issue_ready, 1);
        chk("t1_mpe_c0", a_mpe, 2'b01);
      end
      if (c == 1) chk("t1_mpe_c1", a_mpe, 2'b10);
      if (c == 2) chk("t1_ape_c2", a_ape, 1);
      chk($sformatf("t1_atz_c%0d", c), a_atz, (c == 3));
      chk($sformatf("t1_wbv_c%0d", c), a_wb_valid, (c == 4));
      chk($sformatf("t1_sta_c%0d", c), a_sta, 0);
      if (c == 4) chk("t1_wb_tag", a_wb_tag, 5);
      nxt();
    end

    // back-to-back MACC on A=1 never stalls; accumulator saved each cycle
    for (int c = 0; c < 6; c++) begin
      a_issue_valid = (c < 2); a_issue_op = 2'b11; a_issue_tag = 5'(8 + c);
      mid();
      if (c < 2) chk($sformatf("a1_macc_ready_c%0d", c), a_issue_ready, 1);
      chk($sformatf("a1_sta_c%0d", c), a_sta, (c == 3 || c == 4));
      nxt();
    end

    // backpressure: freeze with wb_tag stable, then drain 1 per cycle
    for (int c = 0; c < 12; c++) begin
      a_issue_valid = (c < 4); a_issue_op = 2'b01; a_issue_tag = 5'(10 + c);
      a_wb_ready = !(c >= 4 && c <= 6);
      mid();
      if (c < 4) chk($sformatf("bp_ready_c%0d", c), a_issue_ready, 1);
      if (c >= 4 && c <= 6) begin
        chk($sformatf("bp_hold_wbv_c%0d", c), a_wb_valid, 1);
        chk($sformatf("bp_hold_tag_c%0d", c), a_wb_tag, 10);
        chk($sformatf("bp_hold_en_c%0d", c), {a_mpe, a_ape, a_issue_ready}, 0);
        chk($sformatf("bp_hold_mbo_c%0d", c), a_mbo, 2'b11);
      end
      if (c >= 7 && c <= 10) begin
        chk($sformatf("bp_drain_wbv_c%0d", c), a_wb_valid, 1);
        chk($sformatf("bp_drain_tag_c%0d", c), a_wb_tag, 10 + (c - 7));
      end
      if (c == 11) chk("bp_drained", a_wb_valid, 0);
      nxt();
    end
    a_wb_ready = 1;

    // stall for 3 cycles with 2 ops in flight
    for (int c = 0; c < 10; c++) begin
      a_issue_valid = (c < 2); a_issue_op = 2'b10; a_issue_tag = 5'(20 + c);
      a_stall = (c >= 2 && c <= 4);
      mid();
      if (c >= 2 && c <= 4) begin
        chk($sformatf("st_en_c%0d", c), {a_mpe, a_ape, a_sta, a_issue_ready}, 0);
        chk($sformatf("st_busy_c%0d", c), a_busy, 1);
      end
      chk($sformatf("st_wbv_c%0d", c), a_wb_valid, (c == 7 || c == 8));
      if (c == 7) chk("st_wb_tag_c7", a_wb_tag, 20);
      if (c == 8) chk("st_wb_tag_c8", a_wb_tag, 21);
      nxt();
    end

    // pending writeback handshake completes while stalled
    for (int c = 0; c < 7; c++) begin
      a_issue_valid = (c == 0); a_issue_op = 2'b01; a_issue_tag = 7;
      a_stall = (c == 4 || c == 5);
      mid();
      if (c == 4) begin
        chk("sh_wbv_c4", a_wb_valid, 1);
        chk("sh_ready_c4", a_issue_ready, 0);
      end
      if (c == 5) begin
        chk("sh_wbv_c5", a_wb_valid, 0);
        chk("sh_busy_c5", a_busy, 0);
      end
      nxt();
    end
    a_stall = 0;

    // reset with 3 ops in flight and wb_valid high discards everything
    for (int c = 0; c < 13; c++) begin
      a_issue_valid = (c < 4); a_issue_op = 2'b00; a_issue_tag = 5'(1 + c);
      a_wb_ready = (c >= 6);
      reset = (c == 4);
      mid();
      if (c == 4) begin
        chk("rs_wbv_before", a_wb_valid, 1);
        chk("rs_busy_before", a_busy, 1);
        chk("rs_ready_in_reset", a_issue_ready, 0);
      end
      if (c == 5) begin
        chk("rs_busy_after", a_busy, 0);
        chk("rs_wb_tag_op", {a_wb_op, a_wb_tag}, 0);
      end
      if (c >= 5) chk($sformatf("rs_wbv_c%0d", c), a_wb_valid, 0);
      nxt();
    end
    reset = 0;

    // MACC hazard on M=1 A=2
    sta_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      b_issue_valid = (c <= 2); b_issue_op = 2'b11; b_issue_tag = (c == 0) ? 5'd1 : 5'd2;
      mid();
      if (c == 0) chk("hz_ready_c0", b_issue_ready, 1);
      if (c == 1) chk("hz_ready_c1", b_issue_ready, 0);
      if (c == 2) chk("hz_ready_c2", b_issue_ready, 1);
      if (c == 3 || c == 5) chk($sformatf("hz_sta_c%0d", c), b_sta, 1);
      if (b_sta) sta_cnt++;
      nxt();
    end
    chk("hz_sta_pulses", sta_cnt, 2);

    // MACC followed by a non-MACC op is not a hazard
    for (int c = 0; c < 7; c++) begin
      b_issue_valid = (c < 2); b_issue_op = (c == 0) ? 2'b11 : 2'b01; b_issue_tag = 5'(3 + c);
      mid();
      if (c == 1) chk("hz_add_after_macc", b_issue_ready, 1);
      nxt();
    end

    // ADD through M=3: mult_by_one walks one stage per cycle
    for (int c = 0; c < 7; c++) begin
      c_issue_valid = (c == 0); c_issue_op = 2'b01; c_issue_tag = 6;
      exp_mbo = (c == 1) ? 3'b001 : (c == 2) ? 3'b010 : (c == 3) ? 3'b100 : 3'b000;
      mid();
      chk($sformatf("m3_mbo_c%0d", c), c_mbo, exp_mbo);
      chk($sformatf("m3_wbv_c%0d", c), c_wb_valid, (c == 5));
      nxt();
    end

    repeat (3) nxt();
    mid();
    chk("a_q_empty", a_q.size(), 0);
    chk("b_q_empty", b_q.size(), 0);
    chk("c_q_empty", c_q.size(), 0);
    chk("a_idle", {a_mpe, a_ape, a_mbo, a_atz, a_sta, a_wb_valid, a_busy}, 0);
    chk("b_idle", {b_mpe, b_ape, b_mbo, b_atz, b_sta, b_wb_valid, b_busy}, 0);
    chk("c_idle", {c_mpe, c_ape, c_mbo, c_atz, c_sta, c_wb_valid, c_busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
